// File: rtl/rep_seq_checker_if.sv
// Per-channel trigger/consequent inputs and verdict outputs of the repetition checker.
// Master drives stimulus (bench side); slave is the checker.
interface rep_seq_checker_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] trig;
    logic [CHANNELS-1:0] b;
    logic [CHANNELS-1:0] mode;
    logic [CHANNELS-1:0] pass;
    logic [CHANNELS-1:0] fail;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] retrig;
    logic [CHANNELS-1:0] timeout;

    modport master (
        output trig, b, mode,
        input  pass, fail, busy, retrig, timeout
    );

    modport slave (
        input  trig, b, mode,
        output pass, fail, busy, retrig, timeout
    );
endinterface

// File: rtl/rep_seq_checker.sv
// Checks trig |-> b[->N] ##1 b (goto) or b[=N] ##1 b (non-consecutive) per channel; verdicts are
// registered one-cycle pulses after the deciding edge, no backpressure. Timeout under REP_SEQ_CHECKER_TIMEOUT_EN.
module rep_seq_checker #(
    parameter int CHANNELS = 4,
    parameter int N_REP    = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    rep_seq_checker_if.slave chk
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FINAL = 2'd2
    } state_e;

    localparam int            CW      = $clog2(N_REP + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_REP);

    state_e [CHANNELS-1:0]         state_q, state_d;
    logic   [CHANNELS-1:0][CW-1:0] cnt_q, cnt_d;
    logic   [CHANNELS-1:0]         trig_q, rise;
    logic   [CHANNELS-1:0]         mode_q, mode_d;
    logic   [CHANNELS-1:0]         pass_q, pass_d;
    logic   [CHANNELS-1:0]         fail_q, fail_d;
    logic   [CHANNELS-1:0]         retrig_q, retrig_d;
    logic   [CHANNELS-1:0]         busy;

`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [CHANNELS-1:0][TW-1:0] tcnt_q, tcnt_d;
    logic [CHANNELS-1:0]         tmo_q, tmo_d;
`endif

    // $rose equivalent; trig_q resets low so a level already high out of reset is a rise.
    assign rise = chk.trig & ~trig_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        pass_d   = '0;
        fail_d   = '0;
        retrig_d = '0;
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        tmo_d    = '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            retrig_d[c] = rise[c] && (state_q[c] != IDLE);
            case (state_q[c])
                IDLE: begin
                    if (rise[c]) begin
                        // Overlapping implication: b on the trigger cycle already counts.
                        mode_d[c]  = chk.mode[c];
                        cnt_d[c]   = CW'(chk.b[c]);
                        state_d[c] = (chk.b[c] && (N_REP == 1)) ? FINAL : COUNT;
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
                        tcnt_d[c]  = '0;
`endif
                    end
                end
                COUNT: begin
                    if (chk.b[c]) begin
                        if (cnt_q[c] + CW'(1) >= CNT_MAX) begin
                            cnt_d[c]   = CNT_MAX;
                            state_d[c] = FINAL;
                        end else begin
                            cnt_d[c] = cnt_q[c] + CW'(1);
                        end
                    end
                end
                FINAL: begin
                    if (chk.b[c]) begin
                        pass_d[c]  = 1'b1;
                        state_d[c] = IDLE;
                    end else if (!mode_q[c]) begin
                        fail_d[c]  = 1'b1;
                        state_d[c] = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
            // Deadline edge only forces a fail if nothing else moved the FSM on that same edge.
            if (state_q[c] != IDLE) begin
                if (tcnt_q[c] != T_LAST) begin
                    tcnt_d[c] = tcnt_q[c] + TW'(1);
                end else if (state_d[c] == state_q[c]) begin
                    fail_d[c]  = 1'b1;
                    tmo_d[c]   = 1'b1;
                    state_d[c] = IDLE;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= {CHANNELS{IDLE}};
            cnt_q    <= '0;
            trig_q   <= '0;
            mode_q   <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            retrig_q <= '0;
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
            tcnt_q   <= '0;
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            trig_q   <= chk.trig;
            mode_q   <= mode_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            retrig_q <= retrig_d;
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        busy = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            busy[c] = (state_q[c] != IDLE);
        end
    end

    assign chk.pass   = pass_q;
    assign chk.fail   = fail_q;
    assign chk.busy   = busy;
    assign chk.retrig = retrig_q;
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
    assign chk.timeout = tmo_q;
`else
    assign chk.timeout = '0;
`endif

endmodule

// File: tb/tb_rep_seq_checker.sv
// Directed bench for rep_seq_checker: per-cycle vector table on channels 0/1 plus hand-written
// sequences for verdict-cycle retrigger, async reset, rise out of reset and timeout.
module tb_rep_seq_checker;
    localparam int CH = 4;
    localparam int NR = 3;
    localparam int TO = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rep_seq_checker_if #(.CHANNELS(CH)) bus ();

    rep_seq_checker #(
        .CHANNELS(CH),
        .N_REP   (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .chk  (bus)
    );

    // One row = inputs for one edge and the outputs expected right after it.
    typedef struct packed {
        logic t;
        logic b;
        logic m;
        logic ep;
        logic ef;
        logic eb;
        logic er;
    } vec_t;

    logic [6:0] rows [$];
    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [19:0] outs();
        return {bus.pass, bus.fail, bus.busy, bus.retrig, bus.timeout};
    endfunction

    function automatic logic [19:0] mk(input logic [3:0] p, input logic [3:0] f, input logic [3:0] bu,
                                       input logic [3:0] rt, input logic [3:0] to);
        return {p, f, bu, rt, to};
    endfunction

    task automatic check(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got pass/fail/busy/retrig/timeout=%h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] t, input logic [3:0] bb, input logic [3:0] m);
        bus.trig = t;
        bus.b    = bb;
        bus.mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.trig = '0;
        bus.b    = '0;
        bus.mode = '0;
        rst_n    = 1'b0;
        #1;
        check("reset_pulse", outs(), '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        // {t,b,m, pass,fail,busy,retrig}
        rows = '{
            // goto pass
            7'b000_0000, 7'b000_0000, 7'b100_0010, 7'b110_0010, 7'b100_0010,
            7'b110_0010, 7'b100_0010, 7'b110_0010, 7'b110_1000, 7'b000_0000,
            // goto fail
            7'b100_0010, 7'b110_0010, 7'b100_0010, 7'b110_0010, 7'b100_0010,
            7'b110_0010, 7'b100_0100, 7'b000_0000,
            // non-consecutive pass with gap; mode flips after trigger and must be ignored
            7'b101_0010, 7'b110_0010, 7'b100_0010, 7'b110_0010, 7'b100_0010,
            7'b110_0010, 7'b100_0010, 7'b100_0010, 7'b100_0010, 7'b100_0010,
            7'b110_1000, 7'b000_0000,
            // same stimulus in goto mode
            7'b100_0010, 7'b110_0010, 7'b100_0010, 7'b110_0010, 7'b100_0010,
            7'b110_0010, 7'b100_0100, 7'b100_0000, 7'b100_0000, 7'b100_0000,
            7'b110_0000, 7'b000_0000,
            // overlap plus retrigger
            7'b110_0010, 7'b000_0010, 7'b010_0010, 7'b100_0011, 7'b110_0010,
            7'b110_1000, 7'b000_0000
        };

        bus.trig = '0;
        bus.b    = '0;
        bus.mode = '0;
        @(posedge clk);
        #1;
        check("reset_state", outs(), '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            vec_t r;
            r = vec_t'(rows[i]);
            step({2'b00, r.t, r.t}, {2'b00, r.b, r.b}, {2'b00, r.m, r.m});
            check($sformatf("row%0d", i), outs(),
                  mk({2'b00, r.ep, r.ep}, {2'b00, r.ef, r.ef}, {2'b00, r.eb, r.eb},
                     {2'b00, r.er, r.er}, 4'h0));
        end

        // Rise on the verdict edge: retrig with pass, rise ignored, next rise starts a check.
        step(4'h0, 4'h0, 4'h0);
        step(4'h4, 4'h4, 4'h0);
        check("vr_start", outs(), mk(4'h0, 4'h0, 4'h4, 4'h0, 4'h0));
        step(4'h0, 4'h4, 4'h0);
        step(4'h0, 4'h4, 4'h0);
        check("vr_final", outs(), mk(4'h0, 4'h0, 4'h4, 4'h0, 4'h0));
        step(4'h4, 4'h4, 4'h0);
        check("vr_pass_retrig", outs(), mk(4'h4, 4'h0, 4'h0, 4'h4, 4'h0));
        step(4'h0, 4'h0, 4'h0);
        check("vr_ignored", outs(), '0);
        step(4'h4, 4'h0, 4'h0);
        check("vr_restart", outs(), mk(4'h0, 4'h0, 4'h4, 4'h0, 4'h0));
        do_reset();

        // Async reset in the middle of COUNT.
        step(4'h0, 4'h0, 4'h0);
        step(4'h1, 4'h0, 4'h0);
        step(4'h1, 4'h1, 4'h0);
        step(4'h1, 4'h1, 4'h0);
        check("rst_pre_busy", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        #3;
        rst_n    = 1'b0;
        bus.trig = '0;
        #1;
        check("rst_immediate", outs(), '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'h0, 4'h1, 4'h0);
            check($sformatf("rst_no_verdict%0d", i), outs(), '0);
        end
        step(4'h1, 4'h0, 4'h0);
        check("rst_fresh_start", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        step(4'h1, 4'h1, 4'h0);
        step(4'h1, 4'h1, 4'h0);
        check("rst_fresh_count2", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        step(4'h1, 4'h1, 4'h0);
        step(4'h1, 4'h1, 4'h0);
        check("rst_fresh_pass", outs(), mk(4'h1, 4'h0, 4'h0, 4'h0, 4'h0));

        // trig already high when reset releases is a rise.
        bus.trig = 4'h8;
        bus.b    = '0;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(4'h8, 4'h0, 4'h0);
        check("rise_out_of_reset", outs(), mk(4'h0, 4'h0, 4'h8, 4'h0, 4'h0));
        do_reset();

        // Non-consecutive check stuck in FINAL: timeout on the TO-th edge after the trigger.
        step(4'h0, 4'h0, 4'h1);
        step(4'h1, 4'h0, 4'h1);
        for (int i = 1; i <= 3; i++) step(4'h1, 4'h1, 4'h1);
        for (int i = 4; i < TO; i++) step(4'h1, 4'h0, 4'h1);
        check("to_before_deadline", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        step(4'h1, 4'h0, 4'h1);
`ifdef REP_SEQ_CHECKER_TIMEOUT_EN
        check("to_deadline", outs(), mk(4'h0, 4'h1, 4'h0, 4'h0, 4'h1));
        step(4'h1, 4'h0, 4'h1);
        check("to_after", outs(), '0);
`else
        check("to_deadline", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
        step(4'h1, 4'h0, 4'h1);
        check("to_after", outs(), mk(4'h0, 4'h0, 4'h1, 4'h0, 4'h0));
`endif
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
